mem_arbiter: RTL
================

# mem_arbiter

Shares a small number of external memory channels between many requesting consumers (per-thread LSUs or per-core fetchers). It sits between the consumers and the external data or program memory. Each channel runs its own handshake state machine. A shared round-robin pointer decides which consumer each free channel takes, so no consumer is starved.

## Interface
Parameters:
- ADDR_BITS, 8, memory address width
- DATA_BITS, 16, memory data width
- NUM_CONSUMERS, 4, number of requesters (≥1)
- NUM_CHANNELS, 1, number of memory channels (1..NUM_CONSUMERS)
- WRITE_ENABLE, 1, when 0 the write path is tied off: write readies and outputs are 0, and write requests are ignored

Ports (arrays are unpacked, one entry per consumer or channel):
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- consumer_read_valid  in  [NUM_CONSUMERS] x 1  read request; held until matching ready
- consumer_read_address  in  [NUM_CONSUMERS] x ADDR_BITS  read address
- consumer_read_ready  out  [NUM_CONSUMERS] x 1  read response valid
- consumer_read_data  out  [NUM_CONSUMERS] x DATA_BITS  read data; valid while ready=1
- consumer_write_valid / _address / _data  in  per consumer  write request, address, data
- consumer_write_ready  out  [NUM_CONSUMERS] x 1  write done
- mem_read_valid / mem_read_address  out  per channel  memory read request
- mem_read_ready / mem_read_data  in  per channel  memory read response
- mem_write_valid / _address / _data  out  per channel  memory write request
- mem_write_ready  in  per channel  memory write acknowledge

## Operation
- Channel states: IDLE, READ_WAITING, WRITE_WAITING, RELAYING.
- Each consumer has a `claimed` bit. A consumer is eligible when it has read_valid or write_valid set and its `claimed` bit is clear.
- Grant in IDLE:
  - On each edge, the IDLE channels are handled in ascending channel index.
  - Each IDLE channel takes the first eligible consumer, searching from `rr_ptr` upward with wrap-around.
  - A consumer already taken by a lower-index channel in the same cycle is skipped.
  - Read wins over write when a consumer asserts both.
  - The grant sets the consumer's claim bit, latches the consumer index, and latches address and data into the channel.
  - A read grant moves the channel to READ_WAITING; a write grant moves it to WRITE_WAITING.
- `rr_ptr` advances to (last consumer granted this cycle + 1) mod NUM_CONSUMERS. It is unchanged if nothing was granted.
- READ_WAITING:
  - mem_read_valid=1 with the latched address.
  - When mem_read_ready=1: latch mem_read_data into that consumer's read_data, set its read_ready=1, drop mem_read_valid, go to RELAYING.
- WRITE_WAITING: mirrors READ_WAITING using the write signals; no data is returned.
- RELAYING:
  - Holds the consumer's ready=1 until that consumer's corresponding valid is seen low.
  - Then clears ready and the claim bit and returns to IDLE.
- Only the owning channel drives a consumer's ready and data. Unowned consumers read 0.
- The address and data latched at grant are used for the whole transaction. Consumer input changes after grant are ignored.

## Timing
- Reset values:
  - all channels IDLE, rr_ptr=0, all claims 0
  - all mem_*_valid=0, mem addresses and data 0
  - all consumer_*_ready=0, consumer_read_data 0
- Grant: request seen at edge k → mem_*_valid=1 during cycle k+1.
- Memory response: mem_*_ready=1 seen at edge m → consumer ready=1 and mem valid=0 from cycle m+1.
- Minimum read latency from request to consumer ready is 2 cycles when memory answers the same cycle it is asked.
- Release: consumer valid=0 seen at edge r → ready=0 and channel IDLE at r+1. The earliest re-grant is at edge r+1, giving a one-cycle bubble.
- A consumer deasserting valid before ready is a protocol violation; behaviour is undefined.
- mem_*_ready arriving while not WAITING is ignored.
- Reset mid-transaction abandons it immediately; memory must tolerate valid dropping.
- Several channels may grant in the same cycle, and they always grant distinct consumers.

## Structure
- Shared package:
  - channel state enum (2 bits: IDLE=0, READ_WAITING=1, WRITE_WAITING=2, RELAYING=3)
  - handshake-role constants, so core LSU/fetcher code references the same encodings
- Sub-module `rr_pick`: combinational. Inputs are a request mask and a start pointer; outputs are a one-hot grant and a found flag. It is instantiated per channel, with the mask reduced by grants already made by lower channels.
- Per-channel state machines and the claim and rr_ptr registers live in `mem_arbiter`.

## Test plan
- Single read, C=4, M=1: consumer 2 reads 0x10 and memory returns 0xBEEF with 1-cycle latency → consumer_read_ready[2]=1 with data 0xBEEF exactly 3 cycles after the request. Dropping valid clears ready the next cycle.
- Round-robin, C=4, M=1: all consumers request reads continuously, re-asserting after each release → grant order 0,1,2,3,0, and no consumer is served twice before all are served.
- Two channels, M=2: consumers 1 and 3 request in the same cycle → channel 0 takes 1, channel 1 takes 3 in the same edge, and both mem_read_valid are high the next cycle.
- Read/write priority: consumer 0 asserts both read and write → read served first. The write is served after the read releases, and mem_write_data equals the data latched at grant.
- Reset mid-op: assert reset while channel 0 is in READ_WAITING → next cycle all valids and readies are 0 and rr_ptr=0. A fresh request completes normally.
- WRITE_ENABLE=0: a write request from consumer 1 is never granted, and mem_write_valid stays 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: channel states, handshake roles
// and a pointer-width helper used by the arbiter and the consumer-side cores.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        CH_IDLE          = 2'd0,
        CH_READ_WAITING  = 2'd1,
        CH_WRITE_WAITING = 2'd2,
        CH_RELAYING      = 2'd3
    } channel_state_t;

    // Which half of the consumer interface a channel is serving.
    typedef enum logic {
        HS_READ  = 1'b0,
        HS_WRITE = 1'b1
    } hs_role_t;

    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first set mask bit
// at or above `start`, wrapping around to bit 0.
module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]             mask,
    input  logic [ptr_bits(N)-1:0]   start,
    output logic [N-1:0]             grant,
    output logic                     found
);

    logic [2*N-1:0] doubled;
    logic [2*N-1:0] rotated;
    logic [2*N-1:0] spread;
    logic [N-1:0]   first;

    // Rotate so `start` sits at bit 0, priority-encode, then rotate back.
    always_comb begin
        doubled = {mask, mask};
        rotated = doubled >> start;
        first   = '0;
        found   = 1'b0;
        for (int p = 0; p < N; p++) begin
            if (rotated[p] && !found) begin
                first[p] = 1'b1;
                found    = 1'b1;
            end
        end
        spread = {{N{1'b0}}, first} << start;
        grant  = spread[N-1:0] | spread[2*N-1:N];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS requesters; each
// channel runs its own handshake FSM and a shared rr_ptr keeps grants fair.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          consumer_read_valid    [NUM_CONSUMERS],
    input  logic [ADDR_BITS-1:0]          consumer_read_address  [NUM_CONSUMERS],
    output logic                          consumer_read_ready    [NUM_CONSUMERS],
    output logic [DATA_BITS-1:0]          consumer_read_data     [NUM_CONSUMERS],
    input  logic                          consumer_write_valid   [NUM_CONSUMERS],
    input  logic [ADDR_BITS-1:0]          consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]          consumer_write_data    [NUM_CONSUMERS],
    output logic                          consumer_write_ready   [NUM_CONSUMERS],
    output logic                          mem_read_valid         [NUM_CHANNELS],
    output logic [ADDR_BITS-1:0]          mem_read_address       [NUM_CHANNELS],
    input  logic                          mem_read_ready         [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]          mem_read_data          [NUM_CHANNELS],
    output logic                          mem_write_valid        [NUM_CHANNELS],
    output logic [ADDR_BITS-1:0]          mem_write_address      [NUM_CHANNELS],
    output logic [DATA_BITS-1:0]          mem_write_data         [NUM_CHANNELS],
    input  logic                          mem_write_ready        [NUM_CHANNELS],
    output channel_state_t                debug_channel_state    [NUM_CHANNELS],
    output logic [ptr_bits(NUM_CONSUMERS)-1:0] debug_rr_ptr
);

    // Handshake: a consumer holds valid (with stable request) until its ready
    // rises; ready then stays high until the consumer drops valid. On the
    // memory side valid is held until ready is seen, then dropped next cycle.

    localparam int N     = NUM_CONSUMERS;
    localparam int M     = NUM_CHANNELS;
    localparam int PTR_W = ptr_bits(N);
    localparam bit WE_ON = (WRITE_ENABLE != 0);

    channel_state_t         ch_state   [M];
    channel_state_t         ch_state_n [M];
    hs_role_t               ch_role    [M];
    hs_role_t               ch_role_n  [M];
    logic [PTR_W-1:0]       ch_owner   [M];
    logic [PTR_W-1:0]       ch_owner_n [M];
    logic [ADDR_BITS-1:0]   ch_addr    [M];
    logic [ADDR_BITS-1:0]   ch_addr_n  [M];
    logic [DATA_BITS-1:0]   ch_wdata   [M];
    logic [DATA_BITS-1:0]   ch_wdata_n [M];

    logic [N-1:0]           claimed, claimed_n;
    logic [PTR_W-1:0]       rr_ptr, rr_ptr_n;
    logic                   rd_ready_q [N];
    logic                   rd_ready_n [N];
    logic [DATA_BITS-1:0]   rd_data_q  [N];
    logic [DATA_BITS-1:0]   rd_data_n  [N];
    logic                   wr_ready_q [N];
    logic                   wr_ready_n [N];

    logic [N-1:0]           eligible;
    logic [N-1:0]           ch_grant [M];
    logic                   ch_found [M];

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = (consumer_read_valid[i] | (WE_ON & consumer_write_valid[i]))
                          & ~claimed[i];
        end
    end

    // Each channel sees only what lower-index channels left unclaimed.
    for (genvar c = 0; c < M; c++) begin : g_ch
        logic [N-1:0] avail_in;
        logic [N-1:0] avail_out;
        logic [N-1:0] pick_mask;
        logic [N-1:0] pick_grant;
        logic         pick_found;

        if (c == 0) begin : g_first
            assign avail_in = eligible;
        end else begin : g_rest
            assign avail_in = g_ch[c-1].avail_out;
        end

        assign pick_mask = (ch_state[c] == CH_IDLE) ? avail_in : '0;

        rr_pick #(.N(N)) u_pick (
            .mask  (pick_mask),
            .start (rr_ptr),
            .grant (pick_grant),
            .found (pick_found)
        );

        assign avail_out   = avail_in & ~pick_grant;
        assign ch_grant[c] = pick_grant;
        assign ch_found[c] = pick_found;
    end

    always_comb begin
        ch_state_n = ch_state;
        ch_role_n  = ch_role;
        ch_owner_n = ch_owner;
        ch_addr_n  = ch_addr;
        ch_wdata_n = ch_wdata;
        claimed_n  = claimed;
        rr_ptr_n   = rr_ptr;
        rd_ready_n = rd_ready_q;
        rd_data_n  = rd_data_q;
        wr_ready_n = wr_ready_q;
        for (int c = 0; c < M; c++) begin
            case (ch_state[c])
                CH_IDLE: begin
                    for (int i = 0; i < N; i++) begin
                        if (ch_found[c] && ch_grant[c][i]) begin
                            ch_owner_n[c] = PTR_W'(i);
                            claimed_n[i]  = 1'b1;
                            rr_ptr_n      = (i == N - 1) ? '0 : PTR_W'(i + 1);
                            if (consumer_read_valid[i]) begin
                                ch_role_n[c]  = HS_READ;
                                ch_state_n[c] = CH_READ_WAITING;
                                ch_addr_n[c]  = consumer_read_address[i];
                                ch_wdata_n[c] = '0;
                            end else begin
                                ch_role_n[c]  = HS_WRITE;
                                ch_state_n[c] = CH_WRITE_WAITING;
                                ch_addr_n[c]  = consumer_write_address[i];
                                ch_wdata_n[c] = consumer_write_data[i];
                            end
                        end
                    end
                end
                CH_READ_WAITING: begin
                    if (mem_read_ready[c]) begin
                        rd_data_n[ch_owner[c]]  = mem_read_data[c];
                        rd_ready_n[ch_owner[c]] = 1'b1;
                        ch_state_n[c]           = CH_RELAYING;
                    end
                end
                CH_WRITE_WAITING: begin
                    if (mem_write_ready[c]) begin
                        wr_ready_n[ch_owner[c]] = 1'b1;
                        ch_state_n[c]           = CH_RELAYING;
                    end
                end
                CH_RELAYING: begin
                    if ((ch_role[c] == HS_READ) ? !consumer_read_valid[ch_owner[c]]
                                                : !consumer_write_valid[ch_owner[c]]) begin
                        rd_ready_n[ch_owner[c]] = 1'b0;
                        rd_data_n[ch_owner[c]]  = '0;
                        wr_ready_n[ch_owner[c]] = 1'b0;
                        claimed_n[ch_owner[c]]  = 1'b0;
                        ch_state_n[c]           = CH_IDLE;
                    end
                end
                default: ch_state_n[c] = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < M; c++) begin
                ch_state[c] <= CH_IDLE;
                ch_role[c]  <= HS_READ;
                ch_owner[c] <= '0;
                ch_addr[c]  <= '0;
                ch_wdata[c] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                rd_ready_q[i] <= 1'b0;
                rd_data_q[i]  <= '0;
                wr_ready_q[i] <= 1'b0;
            end
            claimed <= '0;
            rr_ptr  <= '0;
        end else begin
            ch_state   <= ch_state_n;
            ch_role    <= ch_role_n;
            ch_owner   <= ch_owner_n;
            ch_addr    <= ch_addr_n;
            ch_wdata   <= ch_wdata_n;
            rd_ready_q <= rd_ready_n;
            rd_data_q  <= rd_data_n;
            wr_ready_q <= wr_ready_n;
            claimed    <= claimed_n;
            rr_ptr     <= rr_ptr_n;
        end
    end

    always_comb begin
        for (int c = 0; c < M; c++) begin
            mem_read_valid[c]      = (ch_state[c] == CH_READ_WAITING);
            mem_read_address[c]    = ch_addr[c];
            mem_write_valid[c]     = WE_ON && (ch_state[c] == CH_WRITE_WAITING);
            mem_write_address[c]   = WE_ON ? ch_addr[c] : '0;
            mem_write_data[c]      = WE_ON ? ch_wdata[c] : '0;
            debug_channel_state[c] = ch_state[c];
        end
        for (int i = 0; i < N; i++) begin
            consumer_read_ready[i]  = rd_ready_q[i];
            consumer_read_data[i]   = rd_data_q[i];
            consumer_write_ready[i] = WE_ON && wr_ready_q[i];
        end
    end

    assign debug_rr_ptr = rr_ptr;

endmodule
